prefetch_align_queue: RTL and testbench

//  Parametrised fetch queue between IF stage and icache/MMU path for RV32IC. Issues word-aligned

---
 rtl/prefetch_align_queue_pkg.sv | 10 +
 rtl/prefetch_align_queue_fifo.sv | 42 ++++
 rtl/prefetch_align_queue.sv | 105 ++++++++++
 tb/tb_prefetch_align_queue.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/prefetch_align_queue_pkg.sv
// prefetch_align_queue_pkg: shared fetch-path types, fetch FSM states and instruction-length helper.
package prefetch_align_queue_pkg;
  typedef enum logic [1:0] {RUN, WAIT_ACK, DISCARD} fetch_state_e;
  typedef struct packed {logic req; logic [31:0] addr;} type_pref2mem_s;
  typedef struct packed {logic ack; logic [31:0] rdata;} type_mem2pref_s;
  typedef struct packed {logic valid; logic [31:0] instr; logic [31:0] pc; logic is_c;} type_pref2if_s;
  function automatic logic is_32b(input logic [15:0] hw);
    return hw[1:0] == 2'b11;
  endfunction
endpackage

// File: rtl/prefetch_align_queue_fifo.sv
// prefetch_align_queue_fifo: halfword circular buffer with 0/1/2 push and pop per cycle and 2-entry peek.
module prefetch_align_queue_fifo #(
  parameter int HW = 8,
  parameter int PW = $clog2(HW) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic [1:0]    push_n_i,
  input  logic [15:0]   push_lo_i,
  input  logic [15:0]   push_hi_i,
  input  logic [1:0]    pop_n_i,
  output logic [15:0]   head0_o,
  output logic [15:0]   head1_o,
  output logic [PW-1:0] count_o
);
  localparam int AW = PW - 1;
  logic [15:0]   mem_q [HW];
  logic [PW-1:0] wr_q, rd_q, wr1, rd1;
  assign wr1 = wr_q + PW'(1);
  assign rd1 = rd_q + PW'(1);
  assign count_o = wr_q - rd_q;
  assign head0_o = mem_q[rd_q[AW-1:0]];
  assign head1_o = mem_q[rd1[AW-1:0]];
  always_ff @(posedge clk) begin
    if (push_n_i != 2'd0) mem_q[wr_q[AW-1:0]] <= push_lo_i;
    if (push_n_i == 2'd2) mem_q[wr1[AW-1:0]] <= push_hi_i;
  end
  // the extra pointer bit distinguishes full from empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_q + PW'(push_n_i);
      rd_q <= rd_q + PW'(pop_n_i);
    end
  end
endmodule

// File: rtl/prefetch_align_queue.sv
// prefetch_align_queue: word fetcher feeding a halfword queue that presents aligned RV32IC instructions.
module prefetch_align_queue
  import prefetch_align_queue_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic [XLEN-1:0] flush_pc_i,
  output logic            mem_req_o,
  output logic [XLEN-1:0] mem_addr_o,
  input  logic            mem_ack_i,
  input  logic [31:0]     mem_rdata_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  output logic            instr_is_c_o
);
  localparam int HW = 2 * DEPTH;
  localparam int PW = $clog2(HW) + 1;
  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d, pend_q, pend_d, pc_q, pc_d, tgt;
  logic            drop_q, drop_d, is32, valid, pop;
  logic [1:0]      push_n, pop_n;
  logic [15:0]     head0, head1;
  logic [PW-1:0]   count, free;
  assign tgt   = {flush_pc_i[XLEN-1:2], 2'b00};
  assign free  = PW'(HW) - count;
  assign is32  = is_32b(head0);
  assign valid = is32 ? count >= PW'(2) : count != '0;
  assign pop   = valid & instr_ready_i & ~flush_i;
  assign pop_n = pop ? (is32 ? 2'd2 : 2'd1) : 2'd0;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pend_d  = pend_q;
    push_n  = 2'd0;
    unique case (state_q)
      RUN: begin
        if (flush_i) addr_d = tgt;
        else if (free >= PW'(2)) state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (flush_i) begin
          addr_d  = mem_ack_i ? tgt : addr_q;
          pend_d  = tgt;
          state_d = mem_ack_i ? RUN : DISCARD;
        end else if (mem_ack_i) begin
          push_n  = drop_q ? 2'd1 : 2'd2;
          addr_d  = addr_q + XLEN'(4);
          state_d = RUN;
        end
      end
      DISCARD: begin
        if (flush_i) pend_d = tgt;
        if (mem_ack_i) begin
          addr_d  = flush_i ? tgt : pend_q;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end
  assign drop_d = flush_i ? flush_pc_i[1] : drop_q & (push_n == 2'd0);
  assign pc_d   = flush_i ? {flush_pc_i[XLEN-1:1], 1'b0} :
                  pop ? pc_q + (is32 ? XLEN'(4) : XLEN'(2)) : pc_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      addr_q  <= {RESET_PC[XLEN-1:2], 2'b00};
      pend_q  <= '0;
      pc_q    <= {RESET_PC[XLEN-1:1], 1'b0};
      drop_q  <= RESET_PC[1];
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pend_q  <= pend_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
    end
  end
  // a pending drop_first skips the low halfword of the first word after a redirect
  prefetch_align_queue_fifo #(.HW(HW), .PW(PW)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (flush_i),
    .push_n_i  (push_n),
    .push_lo_i (drop_q ? mem_rdata_i[31:16] : mem_rdata_i[15:0]),
    .push_hi_i (mem_rdata_i[31:16]),
    .pop_n_i   (pop_n),
    .head0_o   (head0),
    .head1_o   (head1),
    .count_o   (count)
  );
  assign mem_req_o     = state_q != RUN;
  assign mem_addr_o    = addr_q;
  assign instr_valid_o = valid;
  assign instr_o       = valid ? (is32 ? {head1, head0} : {16'h0, head0}) : 32'h0;
  assign instr_pc_o    = pc_q;
  assign instr_is_c_o  = valid & ~is32;
endmodule

// File: tb/tb_prefetch_align_queue.sv
// tb_prefetch_align_queue: random fetch/flush/stall traffic checked against an instruction-stream model of memory.
module tb_prefetch_align_queue;
  logic        clk = 0, rst_n = 0, flush_i = 0, mem_ack_i = 0, instr_ready_i = 0;
  logic [31:0] flush_pc_i = 0, mem_rdata_i = 0;
  logic        mem_req_o, instr_valid_o, instr_is_c_o;
  logic [31:0] mem_addr_o, instr_o, instr_pc_o;
  always #5 clk = ~clk;
  prefetch_align_queue dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .flush_pc_i(flush_pc_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i),
    .mem_rdata_i(mem_rdata_i), .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instr_o(instr_o), .instr_pc_o(instr_pc_o), .instr_is_c_o(instr_is_c_o)
  );
  int          n_vec = 0, n_err = 0;
  logic [31:0] memw [logic [31:0]];
  logic [31:0] mpc, efa, prev_addr, prev_ins, prev_pc;
  logic        mdrop, disc, prev_hold, prev_vhold, prev_c;
  int          occ, wcnt, idle, n_acc;
  logic [31:0] cap_pc[$], cap_in[$];
  int          cap_acc[$];
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] getw(input logic [31:0] a);
    if (!memw.exists(a)) memw[a] = $urandom;
    return memw[a];
  endfunction
  function automatic logic [15:0] hw(input logic [31:0] a);
    logic [31:0] w;
    w = getw({a[31:2], 2'b00});
    return a[1] ? w[31:16] : w[15:0];
  endfunction
  task automatic clear_cap();
    cap_pc.delete();
    cap_in.delete();
    cap_acc.delete();
  endtask
  task automatic do_reset();
    rst_n = 0; flush_i = 0; mem_ack_i = 0; instr_ready_i = 0;
    #3;
    check("rst_req", mem_req_o, 0);
    check("rst_addr", mem_addr_o, 0);
    check("rst_valid", instr_valid_o, 0);
    check("rst_instr", instr_o, 0);
    check("rst_pc", instr_pc_o, 0);
    check("rst_is_c", instr_is_c_o, 0);
    @(posedge clk); #1;
    rst_n = 1;
    mpc = 0; efa = 0; mdrop = 0; disc = 0; occ = 0; wcnt = 0; idle = 0; n_acc = 0;
    prev_hold = 0; prev_vhold = 0;
    clear_cap();
  endtask
  // one clock: drive inputs, check the outputs visible before the edge, advance the model
  task automatic cyc(input logic rdy, input logic fl, input logic [31:0] fpc, input int lat, input logic fack);
    logic        ack;
    logic [15:0] h0, h1;
    logic [31:0] ei;
    int          sz;
    ack = mem_req_o && (fack || wcnt >= lat);
    instr_ready_i = rdy; flush_i = fl; flush_pc_i = fpc; mem_ack_i = ack;
    mem_rdata_i = ack ? getw(mem_addr_o) : $urandom;
    if (mem_req_o) check("addr_align", mem_addr_o[1:0], 0);
    if (prev_hold) begin
      check("req_held", mem_req_o, 1);
      check("addr_held", mem_addr_o, prev_addr);
    end
    if (prev_vhold) begin
      check("hold_valid", instr_valid_o, 1);
      check("hold_instr", instr_o, prev_ins);
      check("hold_pc", instr_pc_o, prev_pc);
      check("hold_is_c", instr_is_c_o, prev_c);
    end
    if (instr_valid_o && rdy && !fl) begin
      h0 = hw(mpc);
      h1 = hw(mpc + 2);
      sz = (h0[1:0] == 2'b11) ? 2 : 1;
      ei = (sz == 2) ? {h1, h0} : {16'h0, h0};
      check("pc", instr_pc_o, mpc);
      check("instr", instr_o, ei);
      check("is_c", instr_is_c_o, sz == 1);
      check("occ_avail", occ >= sz, 1);
      cap_pc.push_back(mpc); cap_in.push_back(ei); cap_acc.push_back(n_acc);
      mpc += 32'(sz * 2);
      occ -= sz;
    end
    if (ack) begin
      if (!fl && !disc) begin
        check("fetch_addr", mem_addr_o, efa);
        occ += mdrop ? 1 : 2;
        mdrop = 0;
        efa += 4;
        n_acc++;
        check("occ_bound", occ <= 8, 1);
      end else disc = 0;
    end
    if (fl) begin
      if (mem_req_o && !ack) disc = 1;
      mpc = {fpc[31:1], 1'b0}; efa = {fpc[31:2], 2'b00}; mdrop = fpc[1]; occ = 0;
    end
    idle = (rdy && !fl && !instr_valid_o) ? idle + 1 : 0;
    if (idle > 80) begin
      check("progress", 0, 1);
      idle = 0;
    end
    prev_hold = mem_req_o && !ack; prev_addr = mem_addr_o;
    prev_vhold = instr_valid_o && !rdy && !fl;
    prev_ins = instr_o; prev_pc = instr_pc_o; prev_c = instr_is_c_o;
    wcnt = (mem_req_o && !ack) ? wcnt + 1 : 0;
    @(posedge clk); #1;
  endtask
  task automatic run_n(input int n, input logic rdy, input int lat);
    for (int i = 0; i < n; i++) cyc(rdy, 0, 0, lat, 0);
  endtask
  task automatic wait_req(input logic need_valid);
    int k;
    k = 0;
    while (!(mem_req_o && (instr_valid_o || !need_valid)) && k < 30) begin
      cyc(0, 0, 0, 50, 0);
      k++;
    end
    check("setup_req", mem_req_o && (instr_valid_o || !need_valid), 1);
  endtask
  task automatic reset_mid();
    wait_req(0);
    do_reset();
    mem_ack_i = 1; mem_rdata_i = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    mem_ack_i = 0;
    check("post_rst_req", mem_req_o, 1);
  endtask
  initial begin
    int rp, fp;
    logic [31:0] fpc;
    memw.delete(); memw[0] = 32'h0000_0013; memw[4] = 32'h0000_0093;
    do_reset();
    run_n(20, 1, 1);
    check("t1_pc0", cap_pc[0], 0); check("t1_in0", cap_in[0], 32'h13);
    check("t1_pc1", cap_pc[1], 4); check("t1_in1", cap_in[1], 32'h93);
    memw.delete(); memw[0] = 32'h4501_4581; memw[4] = 32'h0000_0013;
    do_reset();
    run_n(20, 1, 1);
    check("t2_in0", cap_in[0], 32'h4581); check("t2_pc1", cap_pc[1], 2);
    check("t2_in1", cap_in[1], 32'h4501); check("t2_pc2", cap_pc[2], 4);
    check("t2_in2", cap_in[2], 32'h13);
    memw.delete(); memw[0] = 32'h0513_4581; memw[4] = 32'h0000_0000;
    do_reset();
    run_n(30, 1, 3);
    check("t3_in0", cap_in[0], 32'h4581); check("t3_pc1", cap_pc[1], 2);
    check("t3_in1", cap_in[1], 32'h0000_0513); check("t3_after_w1", cap_acc[1] >= 2, 1);
    memw.delete();
    do_reset();
    wait_req(0);
    cyc(1, 1, 32'h102, 50, 0);
    check("t4_valid", instr_valid_o, 0); check("t4_pc", instr_pc_o, 32'h102);
    clear_cap();
    run_n(30, 1, 2);
    check("t4_first_pc", cap_pc[0], 32'h102);
    do_reset();
    run_n(40, 0, 1);
    check("t5_noreq", mem_req_o, 0); check("t5_occ", occ, 8); check("t5_valid", instr_valid_o, 1);
    run_n(80, 1, 1);
    check("t5_drain", cap_pc.size() >= 8, 1);
    do_reset();
    run_n(4, 0, 1);
    wait_req(1);
    cyc(1, 1, 32'h40, 0, 1);
    check("t6_valid", instr_valid_o, 0); check("t6_pc", instr_pc_o, 32'h40); check("t6_req", mem_req_o, 0);
    run_n(20, 1, 1);
    for (int b = 0; b < 40; b++) begin
      rp = $urandom_range(0, 100);
      fp = $urandom_range(0, 5);
      for (int i = 0; i < 100; i++) begin
        fpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 7)) * 2
                                          : 32'($urandom_range(0, 511)) * 2;
        cyc($urandom_range(0, 99) < rp, $urandom_range(0, 99) < fp, fpc,
            $urandom_range(0, 4), $urandom_range(0, 9) == 0);
      end
      if (b % 10 == 5) reset_mid();
    end
    run_n(40, 1, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
